priority_decoder_seq: RTL and testbench
=======================================

PRIORITY_DECODER_SEQ -- requirements
Module: priority_decoder_seq

Interface
REQ-001 SHALL have parameter: PULSE_LEN, default 4, number of cycles a decoded line is driven high (legal 1..15).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  request code present.
REQ-005 SHALL have port: in_ready  output  1  block can accept a code this cycle.
REQ-006 SHALL have port: in_z  input  1  any-request flag from the encoding side (1 = code meaningful).
REQ-007 SHALL have port: in_code  input  2  encoded line index; 3 = line 3 (highest priority) ... 0 = line 0.
REQ-008 SHALL have port: dec_out  output  4  one-hot decoded line, registered.
REQ-009 SHALL have port: busy  output  1  high in every state other than IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse at the end of each drive.
REQ-011 SHALL have port: err  output  1  one-cycle pulse when a code with in_z=0 is accepted.

Function
REQ-012 SHALL accept a code on a rising edge where in_valid && in_ready.
REQ-013 SHALL implement FSM states IDLE, DRIVE, GAP.
REQ-014 SHALL go IDLE->DRIVE on acceptance with in_z=1; dec_out = 1<<in_code from the next cycle.
REQ-015 SHALL hold dec_out at the latched one-hot value for exactly PULSE_LEN cycles in DRIVE, counted by a 4-bit down-counter.
REQ-016 SHALL go DRIVE->GAP when the counter expires; in GAP, dec_out=4'b0000 and done=1 for exactly one cycle.
REQ-017 SHALL go GAP->IDLE, or GAP->DRIVE when a pending code exists (REQ-027).
REQ-018 SHALL, on acceptance with in_z=0, stay in IDLE, leave dec_out at zero, and pulse err the following cycle.
REQ-019 SHALL ignore in_code when in_z=0; in_code is never decoded unless in_z=1.
REQ-020 SHALL keep dec_out zero-or-one-hot at all times; never more than one bit set.
REQ-021 SHALL make done and err mutually exclusive within a cycle.
REQ-022 SHALL, if PULSE_LEN=1, drive dec_out for exactly one cycle and then enter GAP.

Reset
REQ-023 SHALL, on rst_n low, immediately force state=IDLE, dec_out=0, busy=0, done=0, err=0, counter=0, and clear any pending code.
REQ-024 SHALL, when reset is asserted mid-DRIVE, drop dec_out within the same cycle without asserting done.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-026 SHALL, without DEC_PENDING_BUF_EN, drive in_ready = (state==IDLE); no code is accepted in DRIVE or GAP.
REQ-027 SHALL, with DEC_PENDING_BUF_EN defined, add one pending entry {z, code}.
- in_ready = !pending_full.
- A code accepted in DRIVE/GAP is stored there.
- At the end of GAP a pending z=1 code goes straight to DRIVE, with no IDLE cycle.
- A pending z=0 code pulses err at its acceptance cycle+1.

Structure
REQ-028 SHALL put the state enum, CODE_W=2, LINES=4, and PULSE_LEN bounds in shared package priority_dec_pkg.
REQ-029 SHALL use one combinational sub-module decode_2to4 (code -> one-hot) feeding the dec_out register.

Verification
REQ-030 SHALL cover: reset, then accept z=1 code=2 -> dec_out=4'b0100 for 4 cycles, then 0 with done=1 for one cycle, busy=1 throughout, then IDLE.
REQ-031 SHALL cover: accept z=0 code=3 -> err=1 for one cycle, dec_out stays 0, busy stays 0.
REQ-032 SHALL cover: PULSE_LEN=1, code=0 -> dec_out=4'b0001 for exactly 1 cycle, then GAP.
REQ-033 SHALL cover: rst_n low on the 2nd DRIVE cycle of code=3 -> dec_out=0 immediately, done never asserted, in_ready=1 after release.
REQ-034 SHALL cover: without the macro, in_valid held high during DRIVE -> in_ready=0, no acceptance until IDLE.
REQ-035 SHALL cover: with DEC_PENDING_BUF_EN, code=1 then code=1 back-to-back -> 4 cycles of 4'b0010, 1 zero cycle with done, 4 cycles of 4'b0010, done again.

Source files
------------

// File: rtl/priority_dec_pkg.sv
// -----------------------------------------------------------------------------
// priority_dec_pkg
// Shared definitions for the sequential priority decoder: FSM state encoding,
// code/line widths, drive-counter width and the legal PULSE_LEN range.
// -----------------------------------------------------------------------------
package priority_dec_pkg;

  localparam int CODE_W        = 2;   // encoded line index width
  localparam int LINES         = 4;   // number of decoded lines
  localparam int CNT_W         = 4;   // drive down-counter width
  localparam int PULSE_LEN_MIN = 1;
  localparam int PULSE_LEN_MAX = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Keep an out-of-range PULSE_LEN from wrapping the 4-bit counter.
  function automatic int clamp_pulse_len(input int len);
    if (len < PULSE_LEN_MIN) return PULSE_LEN_MIN;
    if (len > PULSE_LEN_MAX) return PULSE_LEN_MAX;
    return len;
  endfunction

endpackage

// File: rtl/priority_decoder_seq_if.sv
// -----------------------------------------------------------------------------
// priority_decoder_seq_if
// Request/result bundle of the sequential priority decoder.
//   in_valid : request code present            (master -> slave)
//   in_ready : slave can accept a code          (slave  -> master)
//   in_z     : code is meaningful (any request) (master -> slave)
//   in_code  : encoded line index, 3 = highest  (master -> slave)
//   dec_out  : registered one-hot line          (slave  -> master)
//   busy     : slave not idle                   (slave  -> master)
//   done     : end-of-drive pulse               (slave  -> master)
//   err      : code with in_z=0 was accepted    (slave  -> master)
// -----------------------------------------------------------------------------
interface priority_decoder_seq_if;
  import priority_dec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_z;
  logic [CODE_W-1:0] in_code;
  logic [LINES-1:0]  dec_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_z, in_code,
    input  in_ready, dec_out, busy, done, err
  );

  modport slave (
    input  in_valid, in_z, in_code,
    output in_ready, dec_out, busy, done, err
  );
endinterface

// File: rtl/decode_2to4.sv
// -----------------------------------------------------------------------------
// decode_2to4
// Combinational binary-to-one-hot decoder.
//   i_code   : line index
//   o_onehot : exactly one bit set, at position i_code
// -----------------------------------------------------------------------------
module decode_2to4
  import priority_dec_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [LINES-1:0]  o_onehot
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_onehot         = '0;
    o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/priority_decoder_seq.sv
// -----------------------------------------------------------------------------
// priority_decoder_seq
// Accepts an encoded line index and drives the matching one-hot line for
// PULSE_LEN cycles, followed by a one-cycle gap that pulses done. A code
// accepted with in_z=0 is never decoded; it pulses err the following cycle.
//
// Parameters
//   PULSE_LEN : cycles a decoded line stays high (1..15)
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : priority_decoder_seq_if.slave (in_valid/in_ready/in_z/in_code in,
//           dec_out/busy/done/err out)
// Configuration
//   DEC_PENDING_BUF_EN : adds a one-entry pending buffer so a code can be
//                        accepted during DRIVE/GAP and launched straight from
//                        GAP into DRIVE. Undefined: in_ready only in IDLE.
// -----------------------------------------------------------------------------
module priority_decoder_seq
  import priority_dec_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  priority_decoder_seq_if.slave  bus
);

  localparam int              PULSE_EFF = clamp_pulse_len(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_EFF - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINES-1:0]  r_dec;
  logic              r_err;
  logic              r_err_defer;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [LINES-1:0]  w_dec_nxt;
  logic              w_ready;
  logic              w_accept;
  logic              w_err_new;
  logic              w_launch_gap;   // GAP continues directly into DRIVE
  logic [CODE_W-1:0] w_dec_code;
  logic [LINES-1:0]  w_onehot;

  assign w_accept  = bus.in_valid && w_ready;
  assign w_err_new = w_accept && !bus.in_z;

`ifdef DEC_PENDING_BUF_EN
  logic              r_pend_full;
  logic              r_pend_z;
  logic [CODE_W-1:0] r_pend_code;

  assign w_ready = !r_pend_full;
  // A full entry always wins in GAP; with the entry empty, a z=1 code
  // arriving during GAP is launched without passing through the buffer.
  assign w_launch_gap = (r_state == GAP) &&
                        (r_pend_full ? r_pend_z : (w_accept && bus.in_z));
  // The entry is only ever full in DRIVE/GAP, so IDLE always decodes in_code.
  assign w_dec_code = r_pend_full ? r_pend_code : bus.in_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_full <= 1'b0;
      r_pend_z    <= 1'b0;
      r_pend_code <= '0;
    end else if (r_state == GAP) begin
      // Leaving GAP consumes the entry: launched if z=1, dropped if z=0.
      r_pend_full <= 1'b0;
    end else if (w_accept && r_state == DRIVE) begin
      r_pend_full <= 1'b1;
      r_pend_z    <= bus.in_z;
      r_pend_code <= bus.in_code;
    end
  end
`else
  assign w_ready      = (r_state == IDLE);
  assign w_launch_gap = 1'b0;
  assign w_dec_code   = bus.in_code;
`endif

  decode_2to4 u_decode (
    .i_code   (w_dec_code),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dec_nxt   = r_dec;
    unique case (r_state)
      IDLE: begin
        if (w_accept && bus.in_z) begin
          w_state_nxt = DRIVE;
          w_cnt_nxt   = CNT_LOAD;
          w_dec_nxt   = w_onehot;
        end
      end
      DRIVE: begin
        if (r_cnt == '0) begin
          w_state_nxt = GAP;
          w_dec_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      GAP: begin
        if (w_launch_gap) begin
          w_state_nxt = DRIVE;
          w_cnt_nxt   = CNT_LOAD;
          w_dec_nxt   = w_onehot;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_dec_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dec       <= '0;
      r_err       <= 1'b0;
      r_err_defer <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dec   <= w_dec_nxt;
      // done owns the GAP cycle; an err that would land there slips one cycle
      // so the two pulses never coincide.
      r_err       <= (w_err_new && (w_state_nxt != GAP)) || r_err_defer;
      r_err_defer <= w_err_new && (w_state_nxt == GAP);
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.dec_out  = r_dec;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == GAP);
  assign bus.err      = r_err;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_priority_decoder_seq
// Two decoders (PULSE_LEN=4 and PULSE_LEN=1) share one stimulus stream. The
// reference model records, per instance, the cycle on which the current gap
// falls and the active code; every output is then derived from the current
// cycle number. Directed sequences pin the model with literal values, then
// random traffic with occasional resets runs against it.
// -----------------------------------------------------------------------------
module tb_priority_decoder_seq;

  localparam int N   = 2;
  localparam int PL0 = 4;
  localparam int PL1 = 1;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_z     = 1'b0;
  logic [1:0] in_code  = 2'd0;

  always #5 clk = ~clk;

  priority_decoder_seq_if bus0 ();
  priority_decoder_seq_if bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_z     = in_z;
  assign bus0.in_code  = in_code;
  assign bus1.in_valid = in_valid;
  assign bus1.in_z     = in_z;
  assign bus1.in_code  = in_code;

  priority_decoder_seq #(.PULSE_LEN(PL0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  priority_decoder_seq #(.PULSE_LEN(PL1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [3:0] o_dec   [N];
  logic       o_busy  [N];
  logic       o_done  [N];
  logic       o_err   [N];
  logic       o_ready [N];

  assign o_dec[0]   = bus0.dec_out;  assign o_dec[1]   = bus1.dec_out;
  assign o_busy[0]  = bus0.busy;     assign o_busy[1]  = bus1.busy;
  assign o_done[0]  = bus0.done;     assign o_done[1]  = bus1.done;
  assign o_err[0]   = bus0.err;      assign o_err[1]   = bus1.err;
  assign o_ready[0] = bus0.in_ready; assign o_ready[1] = bus1.in_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a job launched on cycle n drives lines on cycles n..n+PL-1 and
  // its gap falls on cycle m_gap = n+PL; any cycle after m_gap is idle.
  int m_gap    [N];
  int m_code   [N];
  int m_err_at [N];
`ifdef DEC_PENDING_BUF_EN
  bit p_v      [N];
  bit p_z      [N];
  int p_code   [N];
`endif

  function automatic int pl_of(input int i);
    return (i == 0) ? PL0 : PL1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_gap[i]    = -100;
        m_code[i]   = 0;
        m_err_at[i] = -100;
`ifdef DEC_PENDING_BUF_EN
        p_v[i] = 1'b0;
`endif
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < N; i++) begin
        bit idle_prev;
        bit ready_prev;
        bit acc;
        idle_prev = (cyc - 1) > m_gap[i];
`ifdef DEC_PENDING_BUF_EN
        ready_prev = !p_v[i];
`else
        ready_prev = idle_prev;
`endif
        acc = in_valid && ready_prev;
        if (acc && idle_prev) begin
          if (in_z) begin
            m_gap[i]  = cyc + pl_of(i);
            m_code[i] = int'(in_code);
          end else begin
            m_err_at[i] = cyc;
          end
        end
`ifdef DEC_PENDING_BUF_EN
        else if (acc) begin
          p_v[i]    = 1'b1;
          p_z[i]    = in_z;
          p_code[i] = int'(in_code);
          if (!in_z) m_err_at[i] = (cyc == m_gap[i]) ? cyc + 1 : cyc;
        end
        if (p_v[i] && cyc == m_gap[i] + 1) begin
          if (p_z[i]) begin
            m_gap[i]  = cyc + pl_of(i);
            m_code[i] = p_code[i];
          end
          p_v[i] = 1'b0;
        end
`endif
      end
    end
  end

  // -------------------------------------------------------------- compare
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [3:0] e_dec;
      logic       e_busy, e_done, e_err, e_ready;
      if (!rst_n) begin
        e_dec = 4'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ready = 1'b1;
      end else begin
        e_busy = (cyc <= m_gap[i]);
        e_done = (cyc == m_gap[i]);
        e_dec  = (cyc < m_gap[i]) ? 4'(1 << m_code[i]) : 4'b0;
        e_err  = (cyc == m_err_at[i]);
`ifdef DEC_PENDING_BUF_EN
        e_ready = !p_v[i];
`else
        e_ready = !e_busy;
`endif
      end
      check($sformatf("dec%0d", i),   32'(o_dec[i]),   32'(e_dec));
      check($sformatf("busy%0d", i),  32'(o_busy[i]),  32'(e_busy));
      check($sformatf("done%0d", i),  32'(o_done[i]),  32'(e_done));
      check($sformatf("err%0d", i),   32'(o_err[i]),   32'(e_err));
      check($sformatf("ready%0d", i), 32'(o_ready[i]), 32'(e_ready));
      check($sformatf("onehot%0d", i), 32'($countones(o_dec[i]) <= 1), 32'd1);
      check($sformatf("done_err_excl%0d", i), 32'(o_done[i] && o_err[i]), 32'd0);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one code for exactly one cycle; returns just after the accepting edge.
  task automatic send(input logic z, input logic [1:0] c);
    in_valid = 1'b1; in_z = z; in_code = c;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic lit0(input string name, input logic [3:0] d, input logic b, input logic dn);
    @(negedge clk);
    check({name, "_dec"},  32'(bus0.dec_out), 32'(d));
    check({name, "_busy"}, 32'(bus0.busy),    32'(b));
    check({name, "_done"}, 32'(bus0.done),    32'(dn));
  endtask

  initial begin
    // Reset state.
    tick(2);
    check("rst_dec0",  32'(bus0.dec_out), 32'd0);
    check("rst_busy0", 32'(bus0.busy),    32'd0);
    check("rst_done0", 32'(bus0.done),    32'd0);
    check("rst_err0",  32'(bus0.err),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready0", 32'(bus0.in_ready), 32'd1);
    tick(1);

    // z=1 code=2: four cycles of 0100, one gap with done, then idle.
    send(1'b1, 2'd2);
    for (int k = 0; k < 4; k++) begin
      lit0("c2_drive", 4'b0100, 1'b1, 1'b0);
      if (k == 0) check("c2_pl1_dec1", 32'(bus1.dec_out), 32'h4);
    end
    lit0("c2_gap", 4'b0000, 1'b1, 1'b1);
    lit0("c2_idle", 4'b0000, 1'b0, 1'b0);
    tick(1);

    // z=0 code=3: err one cycle, nothing decoded, never busy.
    send(1'b0, 2'd3);
    lit0("z0_a", 4'b0000, 1'b0, 1'b0);
    check("z0_err0", 32'(bus0.err), 32'd1);
    lit0("z0_b", 4'b0000, 1'b0, 1'b0);
    check("z0_err0_off", 32'(bus0.err), 32'd0);
    tick(1);

    // PULSE_LEN=1, code=0: one cycle of 0001, then the gap.
    send(1'b1, 2'd0);
    @(negedge clk);
    check("pl1_dec1",  32'(bus1.dec_out), 32'h1);
    check("pl1_done1", 32'(bus1.done),    32'd0);
    @(negedge clk);
    check("pl1_gap_dec1",  32'(bus1.dec_out), 32'h0);
    check("pl1_gap_done1", 32'(bus1.done),    32'd1);
    tick(5);

    // Reset asserted on the second DRIVE cycle of code=3.
    send(1'b1, 2'd3);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dec0",  32'(bus0.dec_out), 32'd0);
    check("mid_rst_done0", 32'(bus0.done),    32'd0);
    check("mid_rst_busy0", 32'(bus0.busy),    32'd0);
    check("mid_rst_done1", 32'(bus1.done),    32'd0);
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready0", 32'(bus0.in_ready), 32'd1);
    check("mid_rel_ready1", 32'(bus1.in_ready), 32'd1);
    tick(1);

`ifndef DEC_PENDING_BUF_EN
    // in_valid held through a whole drive: no acceptance until IDLE.
    in_valid = 1'b1; in_z = 1'b1; in_code = 2'd1;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      lit0("hold_drive", 4'b0010, 1'b1, 1'b0);
      check("hold_ready0", 32'(bus0.in_ready), 32'd0);
    end
    lit0("hold_gap", 4'b0000, 1'b1, 1'b1);
    check("hold_gap_ready0", 32'(bus0.in_ready), 32'd0);
    lit0("hold_idle", 4'b0000, 1'b0, 1'b0);
    check("hold_idle_ready0", 32'(bus0.in_ready), 32'd1);
    lit0("hold_again", 4'b0010, 1'b1, 1'b0);
    tick(1);
    in_valid = 1'b0;
    tick(6);
`else
    // Back-to-back code=1: second code waits in the buffer, no IDLE between.
    in_valid = 1'b1; in_z = 1'b1; in_code = 2'd1;
    tick(1);
    lit0("b2b_d1a", 4'b0010, 1'b1, 1'b0);
    check("b2b_ready_a", 32'(bus0.in_ready), 32'd1);
    tick(1);
    in_valid = 1'b0;
    lit0("b2b_d1b", 4'b0010, 1'b1, 1'b0);
    check("b2b_ready_b", 32'(bus0.in_ready), 32'd0);
    for (int k = 0; k < 2; k++) lit0("b2b_d1c", 4'b0010, 1'b1, 1'b0);
    lit0("b2b_gap1", 4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) lit0("b2b_d2", 4'b0010, 1'b1, 1'b0);
    lit0("b2b_gap2", 4'b0000, 1'b1, 1'b1);
    lit0("b2b_idle", 4'b0000, 1'b0, 1'b0);
    tick(1);
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick(1);
        rst_n    = 1'b1;
      end
      in_valid = ($urandom_range(0, 99) < 40);
      in_z     = ($urandom_range(0, 3) != 0);
      in_code  = 2'($urandom_range(0, 3));
      tick(1);
    end
    in_valid = 1'b0;
    tick(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
